// File: rtl/bcm_matrix_scanner.sv
// Double-half LED matrix scanner with binary-code-modulated colour depth.
// Frame buffer is written while idle; each frame scans every row pair plane by plane.

module bcm_matrix_scanner_ram #(
  parameter int W     = 12,
  parameter int ABITS = 9
) (
  input  logic             clk,
  input  logic             we_i,
  input  logic [ABITS-1:0] addr_i,
  input  logic [W-1:0]     wdata_i,
  output logic [W-1:0]     rdata_o
);
  logic [W-1:0] mem_q [2**ABITS];

  always_ff @(posedge clk) begin
    if (we_i) mem_q[addr_i] <= wdata_i;
    rdata_o <= mem_q[addr_i];
  end
endmodule

module bcm_matrix_scanner #(
  parameter int CDEPTH       = 4,
  parameter int COLS         = 32,
  parameter int ROW_BITS     = 4,
  parameter int MCLK_DIV     = 2,
  parameter int LATCH_CYCLES = 2,
  parameter int BCM_UNIT     = 8,
  localparam int CB          = $clog2(COLS),
  localparam int AW          = 1 + ROW_BITS + CB
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  we,
  input  logic [AW-1:0]         waddr,
  input  logic [3*CDEPTH-1:0]   wpix,
  input  logic                  fstart,
  output logic                  busy,
  output logic                  fend,
  output logic [2:0]            lo_rgb,
  output logic [2:0]            hi_rgb,
  output logic [ROW_BITS-1:0]   row,
  output logic                  mclk,
  output logic                  latch,
  output logic                  oe_n
);
  localparam int SR   = 2**ROW_BITS;
  localparam int PW   = (CDEPTH > 1) ? $clog2(CDEPTH) : 1;
  localparam int DW   = $clog2(2*MCLK_DIV);
  localparam int TMAX = BCM_UNIT << (CDEPTH-1);
  localparam int TW   = $clog2(((TMAX > LATCH_CYCLES) ? TMAX : LATCH_CYCLES) + 1);
  localparam int PIXW = 3*CDEPTH;
  localparam int RA   = ROW_BITS + CB;

  typedef enum logic [2:0] {S_IDLE, S_SHIFT, S_LATCH, S_SHOW, S_DONE} state_e;

  state_e              state_q, state_d;
  logic [ROW_BITS-1:0] srow_q, srow_d, row_q, row_d;
  logic [PW-1:0]       plane_q, plane_d;
  logic [CB-1:0]       col_q, col_d;
  logic [DW-1:0]       div_q, div_d;
  logic [TW-1:0]       tcnt_q, tcnt_d, show_len;
  logic [RA-1:0]       raddr;
  logic [1:0][PIXW-1:0] rd;
  logic [1:0][2:0]     rgb;
  logic [CDEPTH-1:0]   chan;

  // Idle cycles share the read port with the write address; scanning owns it otherwise.
  assign raddr = (state_q == S_IDLE) ? waddr[AW-2:0] : {srow_q, col_q};

  for (genvar h = 0; h < 2; h++) begin : g_half
    bcm_matrix_scanner_ram #(.W(PIXW), .ABITS(RA)) u_ram (
      .clk     (clk),
      .we_i    (we && (state_q == S_IDLE) && (waddr[AW-1] == 1'(h))),
      .addr_i  (raddr),
      .wdata_i (wpix),
      .rdata_o (rd[h])
    );
  end

  assign show_len = TW'(BCM_UNIT) << plane_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      srow_q  <= '0;
      row_q   <= '0;
      plane_q <= '0;
      col_q   <= '0;
      div_q   <= '0;
      tcnt_q  <= '0;
    end else begin
      state_q <= state_d;
      srow_q  <= srow_d;
      row_q   <= row_d;
      plane_q <= plane_d;
      col_q   <= col_d;
      div_q   <= div_d;
      tcnt_q  <= tcnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    srow_d  = srow_q;
    row_d   = row_q;
    plane_d = plane_q;
    col_d   = col_q;
    div_d   = div_q;
    tcnt_d  = tcnt_q;
    case (state_q)
      S_IDLE: if (fstart) begin
        state_d = S_SHIFT;
        srow_d  = '0;
        plane_d = '0;
        col_d   = '0;
        div_d   = '0;
      end
      S_SHIFT: if (div_q == DW'(2*MCLK_DIV-1)) begin
        div_d = '0;
        if (col_q == CB'(COLS-1)) begin
          col_d   = '0;
          tcnt_d  = '0;
          state_d = S_LATCH;
        end else begin
          col_d = col_q + 1'b1;
        end
      end else begin
        div_d = div_q + 1'b1;
      end
      S_LATCH: if (tcnt_q == TW'(LATCH_CYCLES-1)) begin
        tcnt_d  = '0;
        row_d   = srow_q;
        state_d = S_SHOW;
      end else begin
        tcnt_d = tcnt_q + 1'b1;
      end
      S_SHOW: if (tcnt_q == show_len - TW'(1)) begin
        tcnt_d = '0;
        if (plane_q != PW'(CDEPTH-1)) begin
          plane_d = plane_q + 1'b1;
          state_d = S_SHIFT;
        end else if (srow_q != ROW_BITS'(SR-1)) begin
          plane_d = '0;
          srow_d  = srow_q + 1'b1;
          state_d = S_SHIFT;
        end else begin
          state_d = S_DONE;
        end
      end else begin
        tcnt_d = tcnt_q + 1'b1;
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Colour bits are forced low outside the scan so idle pins sit at their reset levels.
  always_comb begin
    rgb  = '0;
    chan = '0;
    if (state_q inside {S_SHIFT, S_LATCH, S_SHOW}) begin
      for (int h = 0; h < 2; h++) begin
        for (int k = 0; k < 3; k++) begin
          chan      = rd[h][k*CDEPTH +: CDEPTH];
          rgb[h][k] = chan[plane_q];
        end
      end
    end
  end

  assign lo_rgb = rgb[0];
  assign hi_rgb = rgb[1];
  assign busy   = (state_q != S_IDLE);
  assign fend   = (state_q == S_DONE);
  assign latch  = (state_q == S_LATCH);
  assign oe_n   = (state_q != S_SHOW);
  assign mclk   = (state_q == S_SHIFT) && (div_q >= DW'(MCLK_DIV));
  assign row    = row_q;
endmodule

// File: tb/tb_bcm_matrix_scanner.sv
// Bench for bcm_matrix_scanner: frame-timeline reference model checked every cycle,
// plus literal checks on one hand-analysed frame.

module tb_bcm_matrix_scanner;
  localparam int CDEPTH = 4, COLS = 32, ROW_BITS = 4, MCLK_DIV = 2, LATCH_CYCLES = 2, BCM_UNIT = 8;
  localparam int SR = 2**ROW_BITS, AW = 1 + ROW_BITS + 5, NW = SR*COLS;
  localparam int SH = COLS*2*MCLK_DIV;
  localparam int ROWLEN = CDEPTH*(SH + LATCH_CYCLES) + BCM_UNIT*((1 << CDEPTH) - 1);
  localparam int F = SR*ROWLEN;

  logic clk = 1'b0;
  logic reset, we, fstart;
  logic [AW-1:0] waddr;
  logic [3*CDEPTH-1:0] wpix;
  logic busy, fend, mclk, latch, oe_n;
  logic [2:0] lo_rgb, hi_rgb;
  logic [ROW_BITS-1:0] row;

  bcm_matrix_scanner dut (
    .clk(clk), .reset(reset), .we(we), .waddr(waddr), .wpix(wpix), .fstart(fstart),
    .busy(busy), .fend(fend), .lo_rgb(lo_rgb), .hi_rgb(hi_rgb), .row(row),
    .mclk(mclk), .latch(latch), .oe_n(oe_n)
  );

  always #5 clk = ~clk;

  int total = 0, bad = 0;
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: which phase of the frame timeline a cycle offset falls in.
  typedef struct packed {
    logic fend, mclk, latch, oe_n, rgbv;
    int row, s, p, c;
  } exp_t;

  function automatic exp_t expect_at(input int n, input int row0);
    exp_t e;
    int r, d;
    e = '0;
    e.oe_n = 1'b1;
    if (n >= F) begin
      e.fend = 1'b1;
      e.row = SR - 1;
      return e;
    end
    e.s = n / ROWLEN;
    r = n % ROWLEN;
    while (r >= SH + LATCH_CYCLES + (BCM_UNIT << e.p)) begin
      r = r - (SH + LATCH_CYCLES + (BCM_UNIT << e.p));
      e.p = e.p + 1;
    end
    if (r < SH) begin
      e.c = r / (2*MCLK_DIV);
      d = r % (2*MCLK_DIV);
      e.mclk = (d >= MCLK_DIV);
      e.rgbv = (d >= 1);
    end else if (r < SH + LATCH_CYCLES) e.latch = 1'b1;
    else e.oe_n = 1'b0;
    e.row = (!e.oe_n || e.p > 0) ? e.s : ((e.s == 0) ? row0 : e.s - 1);
    return e;
  endfunction

  function automatic logic [2:0] pixbits(input logic [11:0] px, input int p);
    logic [11:0] t;
    logic [2:0] b;
    b = '0;
    for (int k = 0; k < 3; k++) begin
      t = px >> (k*CDEPTH + p);
      b[k] = t[0];
    end
    return b;
  endfunction

  logic [11:0] m_mem [2][NW];
  bit m_active = 1'b0;
  int m_n = 0, m_row = 0, m_row0 = 0, m_fends = 0;

  always @(posedge clk) begin
    if (reset) begin
      m_active <= 1'b0;
      m_row <= 0;
    end else if (!m_active) begin
      if (we) m_mem[waddr[AW-1]][waddr[AW-2:0]] <= wpix;
      if (fstart) begin
        m_active <= 1'b1;
        m_n <= 0;
        m_row0 <= m_row;
      end
    end else begin
      if (m_n == F) begin
        m_active <= 1'b0;
        m_row <= SR - 1;
        m_fends <= m_fends + 1;
      end
      m_n <= m_n + 1;
    end
  end

  exp_t e_cur;
  always_comb e_cur = expect_at(m_n, m_row0);

  bit chk_en = 1'b0;
  always @(negedge clk) if (chk_en) begin
    chk("busy", busy, m_active);
    if (!m_active) begin
      chk("idle_fend", fend, 0);
      chk("idle_mclk", mclk, 0);
      chk("idle_latch", latch, 0);
      chk("idle_oe_n", oe_n, 1);
      chk("idle_row", row, m_row);
      chk("idle_lo", lo_rgb, 0);
      chk("idle_hi", hi_rgb, 0);
    end else begin
      chk("fend", fend, e_cur.fend);
      chk("mclk", mclk, e_cur.mclk);
      chk("latch", latch, e_cur.latch);
      chk("oe_n", oe_n, e_cur.oe_n);
      chk("row", row, e_cur.row);
      if (e_cur.rgbv) begin
        chk("lo_rgb", lo_rgb, pixbits(m_mem[0][e_cur.s*COLS + e_cur.c], e_cur.p));
        chk("hi_rgb", hi_rgb, pixbits(m_mem[1][e_cur.s*COLS + e_cur.c], e_cur.p));
      end
    end
  end

  // Waveform statistics for the literal checks.
  int run_len = 0, rises = 0, fend_cnt = 0;
  int runs[$], rises_q[$], rows_q[$];
  logic [2:0] samp[$], hsamp[$];
  logic p_oe = 1'b1, p_mclk = 1'b0, p_latch = 1'b0, p_rst = 1'b1;
  logic [ROW_BITS-1:0] p_row = '0;

  always @(negedge clk) if (chk_en) begin
    if (!oe_n) run_len <= run_len + 1;
    else if (!p_oe) begin
      runs.push_back(run_len);
      run_len <= 0;
    end
    if (p_oe && !oe_n) rows_q.push_back(int'(row));
    if (mclk && !p_mclk) begin
      rises <= rises + 1;
      samp.push_back(lo_rgb);
      hsamp.push_back(hi_rgb);
    end
    if (latch && !p_latch) begin
      rises_q.push_back(rises);
      rises <= 0;
    end
    if (row !== p_row && !p_rst) chk("row_change_blanked", p_oe, 1);
    if (latch) chk("latch_blanked", oe_n, 1);
    if (fend) fend_cnt <= fend_cnt + 1;
    p_oe <= oe_n;
    p_mclk <= mclk;
    p_latch <= latch;
    p_row <= row;
    p_rst <= reset;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_in();
    we = 1'b0;
    fstart = 1'b0;
    waddr = '0;
    wpix = '0;
  endtask

  task automatic fill(input bit rnd);
    for (int a = 0; a < 2*NW; a++) begin
      tick();
      we = 1'b1;
      waddr = AW'(a);
      wpix = rnd ? 12'($urandom) : ((a == 0) ? 12'h5A3 : 12'h000);
    end
  endtask

  task automatic start();
    tick();
    we = 1'b0;
    fstart = 1'b1;
    tick();
    fstart = 1'b0;
  endtask

  // k counts cycles after the accepting edge; fend is due at k == F+1.
  task automatic run_frame(input bit junk, input bit poke, input int stop_n, output int k);
    k = 0;
    while (1) begin
      @(negedge clk);
      k++;
      if (fend) break;
      if (stop_n >= 0 && k - 1 == stop_n) break;
      if (k > F + 100) begin
        chk("frame_timeout", k, F + 1);
        break;
      end
      tick();
      if (junk) begin
        we = 1'($urandom_range(0, 1));
        waddr = AW'($urandom);
        wpix = 12'($urandom);
        fstart = ($urandom_range(0, 15) == 0);
      end else if (poke && k == 3000) begin
        we = 1'b1;
        waddr = '0;
        wpix = 12'h000;
        fstart = 1'b1;
      end else idle_in();
    end
    if (stop_n < 0) begin
      tick();
      idle_in();
    end
  endtask

  int k, rb, qb, wb, sb;
  localparam int STOP_N = 7*ROWLEN + (SH + LATCH_CYCLES + 8) + (SH + LATCH_CYCLES + 16) + SH + LATCH_CYCLES + 3;

  initial begin
    reset = 1'b1;
    idle_in();
    @(posedge clk);
    #1;
    chk_en = 1'b1;
    tick();
    reset = 1'b0;
    repeat (10) tick();
    @(negedge clk);
    chk("rst_busy", busy, 0);
    chk("rst_oe_n", oe_n, 1);
    chk("rst_row", row, 0);
    chk("rst_lo", lo_rgb, 0);

    // Frame 1: single pixel 5A3 at address 0, with a dropped write and a stray fstart mid-scan.
    fill(1'b0);
    rb = runs.size(); qb = rises_q.size(); wb = rows_q.size(); sb = samp.size();
    start();
    run_frame(1'b0, 1'b1, -1, k);
    chk("f1_fend_time", k, F + 1);
    chk("f1_runs", runs.size() - rb, SR*CDEPTH);
    chk("f1_latches", rises_q.size() - qb, SR*CDEPTH);
    chk("f1_rows", rows_q.size() - wb, SR*CDEPTH);
    chk("f1_samples", samp.size() - sb, SR*CDEPTH*COLS);
    if (runs.size() - rb == SR*CDEPTH && rises_q.size() - qb == SR*CDEPTH && rows_q.size() - wb == SR*CDEPTH) begin
      for (int i = 0; i < SR*CDEPTH; i++) begin
        chk("f1_run_len", runs[rb + i], BCM_UNIT << (i % CDEPTH));
        chk("f1_mclk_rises", rises_q[qb + i], COLS);
        chk("f1_row_seq", rows_q[wb + i], i / CDEPTH);
      end
    end
    if (samp.size() - sb == SR*CDEPTH*COLS) begin
      chk("f1_p0_col0", samp[sb], 3'h5);
      chk("f1_p1_col0", samp[sb + 32], 3'h3);
      chk("f1_p2_col0", samp[sb + 64], 3'h4);
      chk("f1_p3_col0", samp[sb + 96], 3'h2);
      chk("f1_p0_col1", samp[sb + 1], 3'h0);
      chk("f1_hi_col0", hsamp[sb], 3'h0);
    end

    // Frame 2: the mid-scan write must not have landed.
    sb = samp.size();
    start();
    run_frame(1'b0, 1'b0, -1, k);
    chk("f2_fend_time", k, F + 1);
    if (samp.size() > sb) chk("f2_old_pixel", samp[sb], 3'h5);
    else chk("f2_samples", samp.size() - sb, 1);
    tick();
    chk("f2_fend_count", fend_cnt, 2);

    // Frame 3: random image, junk inputs while busy, reset during row 7 plane 2 SHOW.
    fill(1'b1);
    start();
    run_frame(1'b1, 1'b0, STOP_N, k);
    chk("f3_in_show", oe_n, 0);
    tick();
    reset = 1'b1;
    we = 1'b0;
    fstart = 1'b0;
    tick();
    reset = 1'b0;
    @(negedge clk);
    chk("mid_rst_oe_n", oe_n, 1);
    chk("mid_rst_row", row, 0);
    chk("mid_rst_busy", busy, 0);

    // Frame 4: full frame after the aborted one.
    start();
    run_frame(1'b1, 1'b0, -1, k);
    chk("f4_fend_time", k, F + 1);
    repeat (5) tick();
    chk("fend_total", fend_cnt, m_fends);
    chk("fend_total_lit", fend_cnt, 3);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
